// File: rtl/pdm_capture_ctrl.sv
// +------------------------------------------------------------------------+
// | pdm_capture_ctrl : PDM capture sequencer with warm-up discard, PCM FIFO |
// | and watermark/overflow interrupt. Option: PDM_CAPTURE_OVERWRITE_EN.     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module pdm_capture_ctrl #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int WARMUP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     flush,
    input  logic [WARMUP_W-1:0]      warmup,
    input  logic [$clog2(DEPTH):0]   watermark,
    input  logic                     pcm_valid,
    input  logic [WIDTH-1:0]         pcm_data,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic                     pdm_enable,
    output logic                     busy,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] C_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WARMUP_W-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic                pdm_enable_q, pdm_enable_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic w_push_req;
    logic w_full;
    logic w_do_pop;
    logic w_push_ok;
    logic w_rd_adv;
    logic w_ovf_evt;
    logic w_mem_we;

    always_comb begin
        w_push_req = pcm_valid && (state_q == CAPTURE);
        w_full     = (level_q == C_FULL);
        w_do_pop   = pop && (level_q != '0);
        w_ovf_evt  = w_push_req && w_full && !w_do_pop && !flush;
`ifdef PDM_CAPTURE_OVERWRITE_EN
        // Full without a pop: drop the oldest entry to make room for the newest.
        w_push_ok  = w_push_req;
        w_rd_adv   = w_do_pop || w_ovf_evt;
`else
        w_push_ok  = w_push_req && (!w_full || w_do_pop);
        w_rd_adv   = w_do_pop;
`endif
        w_mem_we   = w_push_ok && !flush;
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wcnt_d  = warmup;
                        state_d = (warmup != '0) ? WARMUP : CAPTURE;
                    end
                end
                WARMUP: begin
                    if (pcm_valid) begin
                        wcnt_d = wcnt_q - WARMUP_W'(1);
                        if (wcnt_q == WARMUP_W'(1)) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: state_d = CAPTURE;
                default: state_d = IDLE;
            endcase
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_rd_adv)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(w_push_ok) - LW'(w_rd_adv);
        end

        if (w_ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        pdm_enable_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            pdm_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            pdm_enable_q <= pdm_enable_d;
        end
    end

    // Sample storage carries no reset; emptiness is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= pcm_data;
        end
    end

    assign pdm_enable = pdm_enable_q;
    assign busy       = pdm_enable_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign rd_data    = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign irq        = ((watermark != '0) && (level_q >= watermark)) || overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with a reference model and a queue of
// expected FIFO contents checked against the DUT after every clock.
`default_nettype none

module tb_pdm_capture_ctrl;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 16;
    localparam int WARMUP_W = 8;
    localparam int LW       = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start, stop, flush, pcm_valid, pop, clr_ovf;
    logic [WARMUP_W-1:0] warmup;
    logic [LW-1:0]       watermark;
    logic [WIDTH-1:0]    pcm_data;
    logic                pdm_enable, busy, overflow, irq;
    logic [WIDTH-1:0]    rd_data;
    logic [LW-1:0]       level;

    always #5 clk = ~clk;

    pdm_capture_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WARMUP_W(WARMUP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .flush      (flush),
        .warmup     (warmup),
        .watermark  (watermark),
        .pcm_valid  (pcm_valid),
        .pcm_data   (pcm_data),
        .pop        (pop),
        .clr_ovf    (clr_ovf),
        .pdm_enable (pdm_enable),
        .busy       (busy),
        .rd_data    (rd_data),
        .level      (level),
        .overflow   (overflow),
        .irq        (irq)
    );

    typedef enum {M_IDLE, M_WARM, M_CAP} mstate_t;
    mstate_t          m_state = M_IDLE;
    int               m_wcnt  = 0;
    logic             m_ovf   = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [WIDTH-1:0] head;
        int               sz;
        logic             exp_irq;
        sz      = exp_q.size();
        head    = (sz == 0) ? '0 : exp_q[0];
        exp_irq = ((watermark != 0) && (sz >= int'(watermark))) || m_ovf;
        check({ctx, ".level"},      32'(level),      32'(sz));
        check({ctx, ".rd_data"},    32'(rd_data),    32'(head));
        check({ctx, ".overflow"},   32'(overflow),   32'(m_ovf));
        check({ctx, ".busy"},       32'(busy),       32'(m_state != M_IDLE));
        check({ctx, ".pdm_enable"}, 32'(pdm_enable), 32'(m_state != M_IDLE));
        check({ctx, ".irq"},        32'(irq),        32'(exp_irq));
    endtask

    // One clock with the given inputs; the model advances alongside the DUT.
    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic p,
                        input logic st, input logic sp, input logic fl,
                        input logic co, input string ctx);
        logic mpush;
        logic dpop;
        logic ovf_evt;
        pcm_valid = v; pcm_data = d; pop = p;
        start = st; stop = sp; flush = fl; clr_ovf = co;
        mpush   = v && (m_state == M_CAP);
        ovf_evt = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            dpop = p && (exp_q.size() > 0);
            if (mpush && (exp_q.size() == DEPTH) && !dpop) begin
                ovf_evt = 1'b1;
`ifdef PDM_CAPTURE_OVERWRITE_EN
                void'(exp_q.pop_front());
                exp_q.push_back(d);
`endif
            end else begin
                if (dpop)  void'(exp_q.pop_front());
                if (mpush) exp_q.push_back(d);
            end
        end
        if (ovf_evt) m_ovf = 1'b1;
        else if (co) m_ovf = 1'b0;
        if (sp) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (st) begin
                    m_wcnt  = int'(warmup);
                    m_state = (warmup != 0) ? M_WARM : M_CAP;
                end
                M_WARM: if (v) begin
                    if (m_wcnt == 1) m_state = M_CAP;
                    m_wcnt--;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        pcm_valid = 0; pop = 0; start = 0; stop = 0; flush = 0; clr_ovf = 0;
        check_all(ctx);
    endtask

    initial begin
        rst_n = 0; start = 0; stop = 0; flush = 0; pcm_valid = 0; pop = 0;
        clr_ovf = 0; warmup = 0; watermark = 0; pcm_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1;
        tick(0, 0, 0, 0, 0, 0, 0, "idle");
        tick(0, 0, 1, 0, 0, 0, 0, "pop_empty");

        // Warm-up discard: first three samples are dropped.
        warmup = 8'd3;
        tick(0, 0, 0, 1, 0, 0, 0, "wu_start");
        check("wu_start.busy_const", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) tick(1, 16'(i), 0, 0, 0, 0, 0, "wu_valid");
        check("wu.level_const", 32'(level), 32'd2);
        check("wu.head_const", 32'(rd_data), 32'h0004);
        tick(0, 0, 1, 0, 0, 0, 0, "wu_pop");
        check("wu.head_after_pop", 32'(rd_data), 32'h0005);
        tick(0, 0, 1, 0, 1, 0, 0, "wu_pop_stop");
        check("wu.stop_enable", 32'(pdm_enable), 32'd0);

        // Zero warm-up, watermark interrupt.
        warmup = 8'd0; watermark = 4'd4;
        tick(0, 0, 0, 1, 0, 0, 0, "wm_start");
        for (int i = 0; i < 3; i++) tick(1, 16'h0100 + 16'(i), 0, 0, 0, 0, 0, "wm_push");
        check("wm.irq_low_at3", 32'(irq), 32'd0);
        tick(1, 16'h0103, 0, 0, 0, 0, 0, "wm_push4");
        check("wm.irq_high_at4", 32'(irq), 32'd1);
        tick(0, 0, 1, 0, 0, 0, 0, "wm_pop");
        check("wm.irq_low_after_pop", 32'(irq), 32'd0);

        // Flush coincident with a sample.
        tick(1, 16'hDEAD, 0, 0, 0, 1, 0, "flush_push");
        check("flush.level_const", 32'(level), 32'd0);
        check("flush.busy_const", 32'(busy), 32'd1);

        // Overflow: nine samples into an eight-deep FIFO.
        watermark = 4'd0;
        for (int i = 0; i < 9; i++) tick(1, 16'h0010 + 16'(i), 0, 0, 0, 0, 0, "ovf_push");
        check("ovf.flag_const", 32'(overflow), 32'd1);
        check("ovf.level_const", 32'(level), 32'd8);
`ifdef PDM_CAPTURE_OVERWRITE_EN
        check("ovf.head_const", 32'(rd_data), 32'h0011);
`else
        check("ovf.head_const", 32'(rd_data), 32'h0010);
`endif
        tick(0, 0, 0, 0, 0, 0, 1, "ovf_clr");
        check("ovf.cleared", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        tick(1, 16'h0020, 1, 0, 0, 0, 0, "full_pushpop");
        check("fpp.level_const", 32'(level), 32'd8);
        check("fpp.overflow_const", 32'(overflow), 32'd0);
`ifdef PDM_CAPTURE_OVERWRITE_EN
        check("fpp.head_const", 32'(rd_data), 32'h0012);
`else
        check("fpp.head_const", 32'(rd_data), 32'h0011);
`endif
        // Sample arriving with stop in CAPTURE is still pushed.
        tick(1, 16'h0021, 1, 0, 1, 0, 0, "push_with_stop");

        // start and stop together from IDLE.
        tick(0, 0, 0, 1, 1, 0, 0, "start_stop");
        check("ss.busy_const", 32'(busy), 32'd0);

        // Build level=5 with overflow set, then reset asynchronously.
        tick(0, 0, 0, 1, 0, 1, 0, "rst_prep_start");
        for (int i = 0; i < 9; i++) tick(1, 16'h0030 + 16'(i), 0, 0, 0, 0, 0, "rst_prep_push");
`ifndef PDM_CAPTURE_OVERWRITE_EN
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, 0, 0, "rst_prep_pop");
        check("rst_prep.level", 32'(level), 32'd5);
`endif
        watermark = 4'd2;
        @(negedge clk);
        rst_n = 0;
        #1;
        m_state = M_IDLE; m_wcnt = 0; m_ovf = 1'b0; exp_q.delete();
        check("arst.pdm_enable", 32'(pdm_enable), 32'd0);
        check("arst.busy",       32'(busy),       32'd0);
        check("arst.rd_data",    32'(rd_data),    32'd0);
        check("arst.level",      32'(level),      32'd0);
        check("arst.overflow",   32'(overflow),   32'd0);
        check("arst.irq",        32'(irq),        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Post-reset capture with interleaved pops.
        tick(0, 0, 0, 1, 0, 0, 0, "post_start");
        for (int i = 0; i < 6; i++) tick(1, 16'($urandom_range(0, 16'hFFFF)), i[0], 0, 0, 0, 0, "post_mix");
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0, 0, "post_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Capture sequencer for the PDM microphone peripheral. It gates the PDM clock/filter enable, discards a programmable number of warm-up PCM samples after start-up, and buffers the valid PCM words in a small FIFO. It raises a level interrupt on a watermark or on overflow. It sits between the CIC decimator output and the TinyQV register interface, so software can read samples in bursts instead of once per sample.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, 2..16
- `WIDTH`, 16, PCM sample width
- `WARMUP_W`, 8, width of the warm-up sample counter
- `clk`  in  1  system clock (64 MHz nominal)
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a capture session
- `stop`  in  1  one-cycle pulse; ends the session
- `flush`  in  1  one-cycle pulse; empties the FIFO and clears its pointers
- `warmup`  in  WARMUP_W  number of samples discarded after `start`; sampled on start acceptance
- `watermark`  in  $clog2(DEPTH)+1  FIFO level threshold for `irq`; 0 disables the level interrupt
- `pcm_valid`  in  1  one-cycle strobe from the decimator, synchronous to `clk`
- `pcm_data`  in  WIDTH  PCM sample qualified by `pcm_valid`
- `pop`  in  1  consume the FIFO head
- `clr_ovf`  in  1  clears the sticky `overflow` flag
- `pdm_enable`  out  1  enables the PDM clock and filter
- `busy`  out  1  state ≠ IDLE
- `rd_data`  out  WIDTH  FIFO head; 0 when empty
- `level`  out  $clog2(DEPTH)+1  number of entries held, 0..DEPTH
- `overflow`  out  1  sticky: a sample arrived while the FIFO was full
- `irq`  out  1  (`watermark`≠0 && `level`≥`watermark`) || `overflow`

## Operation
- States: IDLE, WARMUP, CAPTURE. `pdm_enable` = (state ≠ IDLE).
- From IDLE, `start`:
  - Loads the warm-up counter with `warmup`.
  - Goes to WARMUP if `warmup`≠0, otherwise straight to CAPTURE.
  - `start` outside IDLE is ignored.
- WARMUP:
  - Each `pcm_valid` decrements the counter; the sample is discarded.
  - When a valid arrives with counter==1, the next state is CAPTURE.
- CAPTURE: each `pcm_valid` pushes `pcm_data` into the FIFO.
- `stop` in any state returns to IDLE next cycle. FIFO contents and `overflow` are retained.
- Simultaneous events:
  - `start` and `stop` together: `stop` wins, state stays or becomes IDLE.
  - `pcm_valid` with `stop` in CAPTURE: the sample is still pushed.
- `pop` on an empty FIFO: ignored, `level` stays 0.
- `pop` with a push in the same cycle: both are performed. When full, `level` stays DEPTH and no overflow is flagged.
- `flush`:
  - Sets `level`←0 and resets the pointers.
  - It overrides a simultaneous push or pop; that sample is lost and no overflow is flagged.
  - `flush` does not change state.
- Push while full without a simultaneous pop: `overflow`←1 (see Configuration for the data effect).
- `clr_ovf` clears `overflow`. If an overflow event occurs in the same cycle, set wins.
- Pointers wrap modulo DEPTH. `level` saturates at exactly DEPTH, never DEPTH+1.
- Asynchronous reset mid-capture:
  - State goes to IDLE; FIFO pointers and `level` go to 0; warm-up counter and `overflow` clear.
  - FIFO storage is not reset.

## Timing
- Reset values: `pdm_enable`=0, `busy`=0, `rd_data`=0, `level`=0, `overflow`=0, `irq`=0.
- State, pointers, `level` and `overflow` are registered. `rd_data`, `busy`, `pdm_enable` and `irq` are combinational from registers only, with no input-to-output paths.
- `start` at cycle N: `pdm_enable`=1 and `busy`=1 at N+1.
- `stop` at cycle N: `pdm_enable`=0 at N+1.
- Push at cycle N: `level` increments and `rd_data` updates (if it was empty) at N+1; `irq` may assert at N+1.
- Pop at cycle N: the next head is on `rd_data` at N+1.
- Latency from `pcm_valid` to readable data: 1 cycle.
- Sustains one push and one pop per cycle.

## Configuration
- `PDM_CAPTURE_OVERWRITE_EN` defined: a push into a full FIFO overwrites the oldest entry. The read pointer advances, `level` stays DEPTH, `overflow`←1, and the FIFO always holds the newest DEPTH samples.
- Undefined (default): a push into a full FIFO drops the incoming sample. The FIFO is unchanged and `overflow`←1.

## Test plan
- Warm-up discard:
  - Stimulus: `warmup`=3, `start`, then 5 valids with data 0x0001..0x0005.
  - Required response: `level`=2, `rd_data`=0x0004; after `pop`, `rd_data`=0x0005.
- Zero warm-up and watermark:
  - Stimulus: `warmup`=0, `watermark`=4, `start`, 4 valids.
  - Required response: `irq` rises the cycle after the 4th push; one `pop` → `irq`=0.
- Overflow:
  - Stimulus: DEPTH=8, 9 valids with data 0x0010..0x0018.
  - Required response: `overflow`=1, `level`=8. Head is 0x0010 by default, or 0x0011 with `PDM_CAPTURE_OVERWRITE_EN`. `clr_ovf` → `overflow`=0.
- Full FIFO with simultaneous push+pop:
  - Stimulus: push and pop in the same cycle while full.
  - Required response: `level`=8, `overflow`=0, head advances.
- Stop/start collision and flush:
  - Stimulus: `start`+`stop` in the same cycle from IDLE.
  - Required response: `busy`=0.
  - Stimulus: `flush` coincident with `pcm_valid` in CAPTURE.
  - Required response: `level`=0, state still CAPTURE.
- Reset mid-capture:
  - Stimulus: assert `rst_n`=0 asynchronously with `level`=5 and `overflow`=1.
  - Required response: all outputs 0 immediately, with no clock edge needed.
